// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : vga_pkg                                                    |
// | Purpose  : 640x480@60 timing defaults and pipeline control type.      |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
package vga_pkg;

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;

   localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
   localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

   localparam int          DEF_IMG_W     = 256;
   localparam int          DEF_IMG_H     = 256;
   localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_0000;
   localparam logic [7:0]  DEF_BORDER    = 8'h00;

   // Sync fields carry pin levels (active-low).
   typedef struct packed {
      logic hsync;
      logic vsync;
      logic visible;
      logic in_img;
   } vga_ctrl_t;

   localparam vga_ctrl_t CTRL_IDLE = '{hsync: 1'b1, vsync: 1'b1, visible: 1'b0, in_img: 1'b0};

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : vga_timing_gen                                             |
// | Purpose  : Pixel/line counters with sync, visible and window decode.  |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FP     = VGA_H_FP,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FP     = VGA_V_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP,
   parameter int IMG_W    = DEF_IMG_W,
   parameter int IMG_H    = DEF_IMG_H
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      pix_en_i,
   output vga_ctrl_t ctrl_o,
   output logic      origin_o
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL + 1);
   localparam int VW      = $clog2(V_TOTAL + 1);
   localparam int X_OFF   = (H_ACTIVE - IMG_W) / 2;
   localparam int Y_OFF   = (V_ACTIVE - IMG_H) / 2;

   localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_VIS_END  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [HW-1:0] X_BEG      = HW'(X_OFF);
   localparam logic [HW-1:0] X_END      = HW'(X_OFF + IMG_W);
   localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_VIS_END  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [VW-1:0] Y_BEG      = VW'(Y_OFF);
   localparam logic [VW-1:0] Y_END      = VW'(Y_OFF + IMG_H);

   logic [HW-1:0] hcount_q, hcount_d;
   logic [VW-1:0] vcount_q, vcount_d;
   logic          h_vis, v_vis, h_img, v_img;

   always_comb begin
      hcount_d = hcount_q;
      vcount_d = vcount_q;
      if (pix_en_i) begin
         if (hcount_q == H_LAST) begin
            hcount_d = '0;
            vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + VW'(1);
         end else begin
            hcount_d = hcount_q + HW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcount_q <= '0;
         vcount_q <= '0;
      end else begin
         hcount_q <= hcount_d;
         vcount_q <= vcount_d;
      end
   end

   assign h_vis = (hcount_q < H_VIS_END);
   assign v_vis = (vcount_q < V_VIS_END);
   assign h_img = (hcount_q >= X_BEG) && (hcount_q < X_END);
   assign v_img = (vcount_q >= Y_BEG) && (vcount_q < Y_END);

   assign ctrl_o.hsync   = !((hcount_q >= H_SYNC_BEG) && (hcount_q < H_SYNC_END));
   assign ctrl_o.vsync   = !((vcount_q >= V_SYNC_BEG) && (vcount_q < V_SYNC_END));
   assign ctrl_o.visible = h_vis && v_vis;
   assign ctrl_o.in_img  = h_vis && v_vis && h_img && v_img;
   assign origin_o       = (hcount_q == '0) && (vcount_q == '0);

endmodule
`default_nettype wire

// File: rtl/vga_frame_scanout.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : vga_frame_scanout                                          |
// | Purpose  : Scans a centred grayscale frame buffer out as VGA video.   |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module vga_frame_scanout
   import vga_pkg::*;
#(
   parameter int          H_ACTIVE  = VGA_H_ACTIVE,
   parameter int          H_FP      = VGA_H_FP,
   parameter int          H_SYNC    = VGA_H_SYNC,
   parameter int          H_BP      = VGA_H_BP,
   parameter int          V_ACTIVE  = VGA_V_ACTIVE,
   parameter int          V_FP      = VGA_V_FP,
   parameter int          V_SYNC    = VGA_V_SYNC,
   parameter int          V_BP      = VGA_V_BP,
   parameter int          IMG_W     = DEF_IMG_W,
   parameter int          IMG_H     = DEF_IMG_H,
   parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
   parameter logic [7:0]  BORDER    = DEF_BORDER
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pix_en,
   output logic [31:0] vga_addr,
   input  logic [7:0]  vga_data,
   output logic        hsync,
   output logic        vsync,
   output logic        blank_n,
   output logic [7:0]  red,
   output logic [7:0]  green,
   output logic [7:0]  blue,
   output logic        frame_start
);

   vga_ctrl_t   ctrl0;
   logic        origin0;

   vga_ctrl_t   ctrl1_q, ctrl1_d;
   logic        origin1_q, origin1_d;
   logic [31:0] ptr_q, ptr_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] ptr_cur;

   logic        hsync_q, hsync_d;
   logic        vsync_q, vsync_d;
   logic        blank_n_q, blank_n_d;
   logic [7:0]  pix_q, pix_d;
   logic        fs_q, fs_d;

   vga_timing_gen #(
      .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
      .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
      .IMG_W    (IMG_W),    .IMG_H (IMG_H)
   ) u_timing (
      .clk      (clk),
      .rst_n    (reset),
      .pix_en_i (pix_en),
      .ctrl_o   (ctrl0),
      .origin_o (origin0)
   );

   // Reload at the origin tick itself so a full-screen image still starts at BASE_ADDR.
   assign ptr_cur = origin0 ? BASE_ADDR : ptr_q;

   always_comb begin
      ctrl1_d   = ctrl1_q;
      origin1_d = origin1_q;
      ptr_d     = ptr_q;
      addr_d    = addr_q;
      hsync_d   = hsync_q;
      vsync_d   = vsync_q;
      blank_n_d = blank_n_q;
      pix_d     = pix_q;
      fs_d      = 1'b0;
      if (pix_en) begin
         ctrl1_d   = ctrl0;
         origin1_d = origin0;
         ptr_d     = ptr_cur;
         if (ctrl0.in_img) begin
            addr_d = ptr_cur;
            ptr_d  = ptr_cur + 32'd1;
         end
         hsync_d   = ctrl1_q.hsync;
         vsync_d   = ctrl1_q.vsync;
         blank_n_d = ctrl1_q.visible;
         if (ctrl1_q.in_img) begin
            pix_d = vga_data;
         end else if (ctrl1_q.visible) begin
            pix_d = BORDER;
         end else begin
            pix_d = 8'h00;
         end
         fs_d = origin1_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrl1_q   <= CTRL_IDLE;
         origin1_q <= 1'b0;
         ptr_q     <= BASE_ADDR;
         addr_q    <= BASE_ADDR;
         hsync_q   <= 1'b1;
         vsync_q   <= 1'b1;
         blank_n_q <= 1'b0;
         pix_q     <= 8'h00;
         fs_q      <= 1'b0;
      end else begin
         ctrl1_q   <= ctrl1_d;
         origin1_q <= origin1_d;
         ptr_q     <= ptr_d;
         addr_q    <= addr_d;
         hsync_q   <= hsync_d;
         vsync_q   <= vsync_d;
         blank_n_q <= blank_n_d;
         pix_q     <= pix_d;
         fs_q      <= fs_d;
      end
   end

   always_ff @(posedge clk) begin
      assert (IMG_W <= H_ACTIVE && IMG_H <= V_ACTIVE)
         else $error("vga_frame_scanout: image larger than the active area");
   end

   assign vga_addr    = addr_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign blank_n     = blank_n_q;
   assign red         = pix_q;
   assign green       = pix_q;
   assign blue        = pix_q;
   assign frame_start = fs_q;

endmodule
`default_nettype wire
